// File: rtl/updown_bcd_display.sv
// Two-digit BCD up/down counter with programmable wrap point, driving a
// time-multiplexed active-low seven-segment display (units on an[0], tens on an[1]).
module updown_bcd_display #(
  parameter int MAX_COUNT   = 99,
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up_down,
  output logic [7:0] count_bcd,
  output logic       wrap,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int             DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0]     MAX_T    = 4'(MAX_COUNT / 10);
  localparam logic [3:0]     MAX_U    = 4'(MAX_COUNT % 10);
  localparam logic [7:0]     MAX_BCD  = {MAX_T, MAX_U};

  logic [3:0]       tens;
  logic [3:0]       units;
  logic [7:0]       count_nxt;
  logic             wrap_nxt;
  logic [DIV_W-1:0] div;
  logic             sel;
  logic [3:0]       digit;
  logic             blank;

  // BCD increment with wrap at MAX_BCD; returns {wrap, tens, units}.
  function automatic logic [8:0] bcd_inc(input logic [7:0] cur);
    logic [8:0] res;
    if (cur == MAX_BCD)
      res = {1'b1, 8'h00};
    else if (cur[3:0] == 4'd9)
      res = {1'b0, cur[7:4] + 4'd1, 4'd0};
    else
      res = {1'b0, cur[7:4], cur[3:0] + 4'd1};
    return res;
  endfunction

  // BCD decrement with wrap from 00 to MAX_BCD; returns {wrap, tens, units}.
  function automatic logic [8:0] bcd_dec(input logic [7:0] cur);
    logic [8:0] res;
    if (cur == 8'h00)
      res = {1'b1, MAX_BCD};
    else if (cur[3:0] == 4'd0)
      res = {1'b0, cur[7:4] - 4'd1, 4'd9};
    else
      res = {1'b0, cur[7:4], cur[3:0] - 4'd1};
    return res;
  endfunction

  // Active-low decoder, bit order {g,f,e,d,c,b,a}; non-BCD input blanks.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign count_bcd = {tens, units};

  always_comb begin
    count_nxt = count_bcd;
    wrap_nxt  = 1'b0;
    if (enable) begin
      if (up_down)
        {wrap_nxt, count_nxt} = bcd_dec(count_bcd);
      else
        {wrap_nxt, count_nxt} = bcd_inc(count_bcd);
    end
  end

  // Counter and refresh state; an is registered alongside the digit select
  // so it always matches the digit that seg is decoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      tens  <= 4'd0;
      units <= 4'd0;
      wrap  <= 1'b0;
      div   <= '0;
      sel   <= 1'b0;
      an    <= 2'b10;
    end else begin
      tens  <= count_nxt[7:4];
      units <= count_nxt[3:0];
      wrap  <= wrap_nxt;
      if (div == DIV_LAST) begin
        div <= '0;
        sel <= ~sel;
        an  <= sel ? 2'b10 : 2'b01;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign digit = sel ? tens : units;
  assign blank = BLANK_LZ && sel && (tens == 4'd0);
  assign seg   = blank ? 7'b1111111 : seg_decode(digit);

endmodule

// File: tb/tb_updown_bcd_display.sv
// Scoreboard bench for updown_bcd_display: three instances cover the default
// wrap point, a MAX_COUNT=12 wrap and BLANK_LZ=0, all with REFRESH_DIV=4.
module tb_updown_bcd_display;

  typedef struct {
    int         which;
    logic [7:0] cnt;
    logic       wrp;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en   [3];
  logic       ud   [3];
  logic [7:0] cnt  [3];
  logic       wrp  [3];
  logic [6:0] seg  [3];
  logic [1:0] an   [3];

  exp_t sb[$];
  int   model [3];
  int   maxv  [3] = '{99, 12, 99};
  int   total = 0;
  int   bad   = 0;

  updown_bcd_display #(.MAX_COUNT(99), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut0 (
    .clk(clk), .reset(reset), .enable(en[0]), .up_down(ud[0]),
    .count_bcd(cnt[0]), .wrap(wrp[0]), .seg(seg[0]), .an(an[0]));
  updown_bcd_display #(.MAX_COUNT(12), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(en[1]), .up_down(ud[1]),
    .count_bcd(cnt[1]), .wrap(wrp[1]), .seg(seg[1]), .an(an[1]));
  updown_bcd_display #(.MAX_COUNT(99), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut2 (
    .clk(clk), .reset(reset), .enable(en[2]), .up_down(ud[2]),
    .count_bcd(cnt[2]), .wrap(wrp[2]), .seg(seg[2]), .an(an[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus on one instance and queues the expected result.
  task automatic drive(input int which, input bit e, input bit d);
    exp_t x;
    bit   w;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    en[which] = e;
    ud[which] = d;
    w = 1'b0;
    if (e) begin
      if (!d) begin
        if (model[which] == maxv[which]) begin model[which] = 0; w = 1'b1; end
        else model[which] = model[which] + 1;
      end else begin
        if (model[which] == 0) begin model[which] = maxv[which]; w = 1'b1; end
        else model[which] = model[which] - 1;
      end
    end
    x.which = which;
    x.cnt   = to_bcd(model[which]);
    x.wrp   = w;
    sb.push_back(x);
    tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin en[i] = 1'b0; ud[i] = 1'b0; model[i] = 0; end
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [1:0] a_exp;
    logic [6:0] s_exp;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cnt[i] !== 8'h00 || wrp[i] !== 1'b0 || an[i] !== 2'b10 || seg[i] !== 7'b1000000) begin
        bad++;
        $display("FAIL reset_state dut%0d cnt=%h wrap=%b an=%b seg=%b want 00 0 10 1000000",
                 i, cnt[i], wrp[i], an[i], seg[i]);
      end
    end
    for (int k = 1; k < 8; k++) begin
      tick();
      a_exp = (k < 4) ? 2'b10 : 2'b01;
      s_exp = (k < 4) ? 7'b1000000 : 7'b1111111;
      total++;
      if (an[0] !== a_exp || seg[0] !== s_exp || cnt[0] !== 8'h00 || wrp[0] !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle k=%0d an=%b seg=%b cnt=%h want an=%b seg=%b cnt=00",
                 k, an[0], seg[0], cnt[0], a_exp, s_exp);
      end
    end
  endtask

  task automatic test_count_up();
    exp_t x;
    int   n;
    for (int k = 0; k < 10; k++) begin
      drive(0, 1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (cnt[x.which] !== x.cnt || wrp[x.which] !== x.wrp) begin
        bad++;
        $display("FAIL count_up step=%0d cnt=%h wrap=%b want %h %b", k, cnt[x.which], wrp[x.which], x.cnt, x.wrp);
      end
    end
    en[0] = 1'b0;
    n = 0;
    while (an[0] !== 2'b01 && n < 10) begin tick(); n++; end
    total++;
    if (an[0] !== 2'b01 || seg[0] !== 7'b1111001) begin
      bad++;
      $display("FAIL tens_one an=%b seg=%b want 01 1111001", an[0], seg[0]);
    end
    n = 0;
    while (an[0] !== 2'b10 && n < 10) begin tick(); n++; end
    total++;
    if (an[0] !== 2'b10 || seg[0] !== 7'b1000000) begin
      bad++;
      $display("FAIL units_zero an=%b seg=%b want 10 1000000", an[0], seg[0]);
    end
  endtask

  task automatic test_wrap_99();
    exp_t x;
    bit   e [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit   d [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 89; k++) begin
      drive(0, 1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (cnt[0] !== x.cnt || wrp[0] !== x.wrp) begin
        bad++;
        $display("FAIL climb99 step=%0d cnt=%h wrap=%b want %h %b", k, cnt[0], wrp[0], x.cnt, x.wrp);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, e[k], d[k]);
      x = sb.pop_front();
      total++;
      if (cnt[0] !== x.cnt || wrp[0] !== x.wrp) begin
        bad++;
        $display("FAIL wrap99 step=%0d cnt=%h wrap=%b want %h %b", k, cnt[0], wrp[0], x.cnt, x.wrp);
      end
    end
  endtask

  task automatic test_max12();
    exp_t x;
    bit   d [17] = '{0,0,0,0,0,0,0,0,0,0,0,0, 0, 1, 1, 0, 0};
    bit   e [17] = '{1,1,1,1,1,1,1,1,1,1,1,1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 17; k++) begin
      drive(1, e[k], d[k]);
      x = sb.pop_front();
      total++;
      if (cnt[1] !== x.cnt || wrp[1] !== x.wrp || cnt[1] > 8'h12) begin
        bad++;
        $display("FAIL max12 step=%0d cnt=%h wrap=%b want %h %b", k, cnt[1], wrp[1], x.cnt, x.wrp);
      end
    end
  endtask

  task automatic test_hold_down();
    exp_t x;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (cnt[0] !== x.cnt || wrp[0] !== x.wrp) begin
        bad++;
        $display("FAIL preset5 step=%0d cnt=%h wrap=%b want %h %b", k, cnt[0], wrp[0], x.cnt, x.wrp);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 1'b1);
      x = sb.pop_front();
      total++;
      if (cnt[0] !== x.cnt || wrp[0] !== x.wrp) begin
        bad++;
        $display("FAIL hold_down step=%0d cnt=%h wrap=%b want %h %b", k, cnt[0], wrp[0], x.cnt, x.wrp);
      end
    end
    total++;
    if (cnt[0] !== 8'h02) begin
      bad++;
      $display("FAIL hold_down_final cnt=%h want 02", cnt[0]);
    end
  endtask

  task automatic test_reset_with_enable();
    logic [1:0] a_exp;
    reset = 1'b1;
    en[0] = 1'b1;
    ud[0] = 1'b1;
    tick();
    reset = 1'b0;
    en[0] = 1'b0;
    model[0] = 0;
    total++;
    if (cnt[0] !== 8'h00 || wrp[0] !== 1'b0 || an[0] !== 2'b10) begin
      bad++;
      $display("FAIL reset_wins cnt=%h wrap=%b an=%b want 00 0 10", cnt[0], wrp[0], an[0]);
    end
    for (int k = 1; k < 8; k++) begin
      tick();
      a_exp = (k < 4) ? 2'b10 : 2'b01;
      total++;
      if (an[0] !== a_exp || cnt[0] !== 8'h00) begin
        bad++;
        $display("FAIL div_restart k=%0d an=%b cnt=%h want %b 00", k, an[0], cnt[0], a_exp);
      end
    end
  endtask

  task automatic test_no_blank();
    exp_t       x;
    logic [6:0] s_exp;
    for (int k = 0; k < 7; k++) begin
      drive(2, 1'b1, 1'b0);
      x = sb.pop_front();
      total++;
      if (cnt[2] !== x.cnt || wrp[2] !== x.wrp) begin
        bad++;
        $display("FAIL noblank_up step=%0d cnt=%h wrap=%b want %h %b", k, cnt[2], wrp[2], x.cnt, x.wrp);
      end
    end
    en[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_exp = (an[2] === 2'b01) ? seg_ref(0) : seg_ref(7);
      total++;
      if ((an[2] !== 2'b01 && an[2] !== 2'b10) || seg[2] !== s_exp || cnt[2] !== 8'h07) begin
        bad++;
        $display("FAIL noblank_seg k=%0d an=%b seg=%b cnt=%h want seg=%b cnt=07", k, an[2], seg[2], cnt[2], s_exp);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin en[i] = 1'b0; ud[i] = 1'b0; model[i] = 0; end
    @(negedge clk);
    test_reset();
    test_count_up();
    test_wrap_99();
    test_max12();
    test_hold_down();
    test_reset_with_enable();
    test_no_blank();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_bcd_display.md
Name: updown_bcd_display

Overview:
- Consumer end of the button-FSM strobe interface.
- Takes single-cycle `enable` strobes, with `up_down` giving direction, and maintains a 2-digit BCD up/down counter that wraps at a programmable maximum.
- Drives a time-multiplexed, active-low, 2-digit seven-segment display.
- Sits between the button FSM and the board display pins.

Parameters:
- MAX_COUNT, 99: highest count value, decimal; legal range 1..99; count wraps MAX_COUNT<->0.
- REFRESH_DIV, 50000: clk cycles each digit is displayed before switching to the other; legal range >=2.
- BLANK_LZ, 1: 1 = blank the tens digit when it is 0; 0 = always show the tens digit.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  count strobe, nominally one cycle wide
- up_down  input  1  direction, sampled with enable: 0 = increment, 1 = decrement
- count_bcd  output  8  current count; [7:4] = tens, [3:0] = units
- wrap  output  1  one-cycle pulse when the count wraps in either direction
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- an  output  2  digit anodes, active-low one-hot; an[0] = units, an[1] = tens

Behaviour:
- Synchronous active-high reset; on a clk edge with reset=1, all state clears regardless of other inputs:
  - count_bcd=8'h00, wrap=0
  - refresh divider=0
  - digit select=units, so an=2'b10, seg=7'b1000000 ('0')
- Counting, on an edge with enable=1 and reset=0:
  - up_down=0: count+1, BCD-correct (units 9 -> 0 carries into tens).
  - up_down=1: count-1, BCD-correct (units 0 -> 9 borrows from tens).
  - New value is visible on count_bcd the cycle after the strobe edge; latency 1.
- Wrap rules:
  - Increment from MAX_COUNT -> 00, wrap=1 for exactly that one cycle.
  - Decrement from 00 -> MAX_COUNT, wrap=1 for exactly that one cycle.
  - wrap is registered and is 0 in every cycle without a wrap.
- enable=0: count holds; up_down is ignored.
- enable held high N consecutive cycles: counts N steps, one per cycle. No internal edge detection; the upstream FSM guarantees one pulse per press.
- Simultaneous reset and enable: reset wins and count becomes 00.
- count_bcd never holds a non-BCD nibble and never exceeds MAX_COUNT.
- Display refresh:
  - Free-running divider counts 0..REFRESH_DIV-1.
  - On the cycle it reaches REFRESH_DIV-1 it returns to 0 and the digit select toggles.
  - Each digit is therefore active for exactly REFRESH_DIV cycles.
- an is registered from the digit select: units -> 2'b10, tens -> 2'b01. Never 2'b00 or 2'b11 out of reset.
- seg is combinational from the digit select and count_bcd via a BCD-to-7-segment decoder, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- BLANK_LZ=1 and tens=0: while the tens digit is selected, seg=7'b1111111; an still toggles normally.
- A count change mid-refresh shows on seg immediately for the currently selected digit. The divider is unaffected.
- The divider is independent of enable and runs continuously.

Test Plan:
- Reset then idle, REFRESH_DIV=4: count_bcd=00, wrap=0, an=10 for 4 cycles, then 01 for 4 cycles. seg=1000000 in the units phase and 1111111 in the tens phase (BLANK_LZ=1).
- 10 single-cycle up strobes from 00: count_bcd goes 01..09 then 8'h10 (BCD carry, not 8'h0A). In the tens phase seg=1111001.
- MAX_COUNT=99, start at 8'h99, one up strobe: count_bcd=8'h00 and wrap=1 for one cycle. Then one down strobe: count_bcd=8'h99 and wrap=1 for one cycle.
- MAX_COUNT=12, count at 8'h12, up strobe: count_bcd=8'h00 with wrap. Down strobe from 8'h00: count_bcd=8'h12. 8'h20 from 8'h19 is never reached.
- enable held high 3 cycles with up_down=1 from 8'h05: count_bcd=8'h02. Then reset asserted together with enable: next cycle count_bcd=8'h00, an=10, divider restarted.
- BLANK_LZ=0, count 8'h07: tens phase shows seg=1000000 and units phase shows seg=1111000.
